muldiv_seq: RTL

Iterative sequencer for the RV32M multiply/divide instructions (funct7 = 7'b0000001), sitting beside the single-cycle ALU in the execute stage. It accepts one operation per Start pulse and runs a shift-add multiply or restoring divide over XLEN cycles. It stalls the pipeline through Busy and returns a registered Result with a one-cycle Done pulse.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
//   op_e       funct3 encoding of the eight M-extension operations
//   state_e    sequencer states
//   MULDIV_FUNCT7  funct7 value that routes an R-type instruction to this block
package muldiv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic op_is_mul(input op_e op);
        return !op[2];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic op_a_signed(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic op_b_signed(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negate.
//   neg      1 = output is -in_val, 0 = pass through
//   in_val   W-bit input
//   out_val  W-bit result
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);
    assign out_val = neg ? -in_val : in_val;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply (shift-add) / divide (restoring) sequencer.
//   clk, rst            clock, asynchronous active-high reset
//   Start, funct3       issue request and operation select (sampled when not Busy)
//   Operand_A/B         rs1 / rs2 values
//   Flush               synchronous abort, returns to IDLE and suppresses Done
//   Busy                high in CALC and FIX (pipeline stall)
//   Done, Result        one-cycle completion pulse and registered result
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves CALC as soon as the
// remaining multiplier bits are all zero.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Operand_A,
    input  logic [XLEN-1:0] Operand_B,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state, state_next;
    op_e                 op;
    logic [2*XLEN-1:0]   acc;     // mul: product; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     opnd;    // mul: multiplicand; div: divisor
    logic [XLEN-1:0]     mplier;
    logic [CW-1:0]       cnt;
    logic                neg_q, neg_r;

    // ---------------- issue decode ----------------
    op_e             op_in;
    logic            a_neg, b_neg, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign op_in = op_e'(funct3);
    assign a_neg = op_a_signed(op_in) & Operand_A[XLEN-1];
    assign b_neg = op_b_signed(op_in) & Operand_B[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_mag_a (.neg(a_neg), .in_val(Operand_A), .out_val(a_mag));
    muldiv_sign_fix #(.W(XLEN)) u_mag_b (.neg(b_neg), .in_val(Operand_B), .out_val(b_mag));

    assign div_zero = !op_is_mul(op_in) && (Operand_B == '0);
    assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                      (Operand_A == XMIN) && (Operand_B == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : Operand_A;
        else if (div_ovf)
            special_res = (op_in == OP_DIV) ? XMIN : '0;
    end

    assign accept = Start && !Flush && (state == ST_IDLE || state == ST_DONE);

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ok, calc_last;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // remainder < divisor always holds, so a failed trial never loses the shifted MSB
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opnd};
    assign div_ok    = !div_diff[XLEN+1];
    assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                        acc[XLEN-2:0], div_ok};

    // On early exit cnt is left at the number of product shifts still owed.
    logic [2*XLEN-1:0] prod;
`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (cnt == '0) || (op_is_mul(op) && (mplier[XLEN-1:1] == '0));
    assign prod      = acc >> cnt;
`else
    assign calc_last = (cnt == '0);
    assign prod      = acc;
`endif

    // ---------------- sign fix / result select ----------------
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        fix_in  = prod;
        fix_neg = neg_q;
        if (!op_is_mul(op)) begin
            if (op == OP_DIV || op == OP_DIVU) begin
                fix_in = {{XLEN{1'b0}}, acc[XLEN-1:0]};
            end else begin
                fix_in  = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
                fix_neg = neg_r;
            end
        end
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix (.neg(fix_neg), .in_val(fix_in), .out_val(fix_out));

    assign fix_res = (op_is_mul(op) && op != OP_MUL) ? fix_out[2*XLEN-1:XLEN]
                                                     : fix_out[XLEN-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
            ST_CALC:          if (calc_last) state_next = ST_FIX;
            ST_FIX:           state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
        if (Flush) state_next = ST_IDLE;
    end

    assign Busy = (state == ST_CALC) || (state == ST_FIX);
    assign Done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= OP_MUL;
            acc    <= '0;
            opnd   <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Result <= '0;
        end else if (accept) begin
            op    <= op_in;
            cnt   <= CW'(XLEN-1);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (op_is_mul(op_in)) begin
                acc    <= '0;
                opnd   <= a_mag;
                mplier <= b_mag;
            end else begin
                acc    <= {{XLEN{1'b0}}, a_mag};
                opnd   <= b_mag;
                mplier <= '0;
            end
            if (special) Result <= special_res;
        end else if (state == ST_CALC) begin
            acc    <= op_is_mul(op) ? mul_next : div_next;
            mplier <= mplier >> 1;
            if (!calc_last) cnt <= cnt - CW'(1);
        end else if (state == ST_FIX && !Flush) begin
            Result <= fix_res;
        end
    end

endmodule
